// File: rtl/memory_control_rr.sv
// memory_control_rr: coherent bus controller joining CPUS private L1 cache pairs
// to a single RAM port. Data traffic goes through a snooping FSM
// (IDLE/SNOOP/LD/SWB/WB) with round-robin owner selection. Instruction fetches
// use their own round-robin pointer and only run while the data side is idle.
// Ports:
//   CLK, nRST                        clock, synchronous active-low reset
//   iREN/iaddr -> iwait/iload        per-core instruction fetch
//   dREN/dWEN/daddr/dstore           per-core data miss / writeback
//     -> dwait/dload
//   cctrans/ccwrite                  per-core coherence request / modified flag
//     -> ccwait/ccinv/ccsnoopaddr
//   ramREN/ramWEN/ramaddr/ramstore   RAM request port
//     <- ramload/ramstate

package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_control_rr
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS  = 4,
    parameter int unsigned WORDS = 2,
    parameter int unsigned IDXW  = $clog2(CPUS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int unsigned   CNTW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, SNOOP, LD, SWB, WB} state_t;

    state_t          state, state_n;
    logic [IDXW-1:0] own, own_n, sup, sup_n, dptr, dptr_n, iptr, iptr_n;
    logic [CNTW-1:0] cnt, cnt_n;

    logic [CPUS-1:0] dreq;
    logic            d_any, i_any, s_any, word_done;
    logic [IDXW-1:0] d_pick, i_pick, s_pick;

    assign dreq = dREN | dWEN;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] x);
        return (32'(x) == CPUS - 1) ? '0 : IDXW'(32'(x) + 1);
    endfunction

    // Round-robin pickers for data and instruction, lowest-index modified snooper
    always_comb begin
        d_any  = 1'b0;
        d_pick = '0;
        i_any  = 1'b0;
        i_pick = '0;
        s_any  = 1'b0;
        s_pick = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            if (!d_any && dreq[IDXW'((32'(dptr) + k) % CPUS)]) begin
                d_any  = 1'b1;
                d_pick = IDXW'((32'(dptr) + k) % CPUS);
            end
            if (!i_any && iREN[IDXW'((32'(iptr) + k) % CPUS)]) begin
                i_any  = 1'b1;
                i_pick = IDXW'((32'(iptr) + k) % CPUS);
            end
            if (!s_any && ccwrite[IDXW'(k)] && (IDXW'(k) != own)) begin
                s_any  = 1'b1;
                s_pick = IDXW'(k);
            end
        end
    end

    // Next-state and bus outputs
    always_comb begin
        state_n     = state;
        own_n       = own;
        sup_n       = sup;
        cnt_n       = cnt;
        dptr_n      = dptr;
        iptr_n      = iptr;
        word_done   = 1'b0;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = {CPUS{ramload}};
        dload       = {CPUS{ramload}};
        ccsnoopaddr = {CPUS{daddr[own]}};

        case (state)
            IDLE: begin
                if (d_any) begin
                    own_n   = d_pick;
                    cnt_n   = '0;
                    state_n = dWEN[d_pick] ? WB : SNOOP;
                end else if (i_any) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[i_pick];
                    if (ramstate == ACCESS) begin
                        iwait[i_pick] = 1'b0;
                        iptr_n        = wrap_inc(i_pick);
                    end
                end
            end
            SNOOP: begin
                ccwait = ~(CPUS'(1) << own);
                ccinv  = cctrans[own] ? ccwait : '0;
                if (s_any) begin
                    sup_n   = s_pick;
                    state_n = SWB;
                end else begin
                    state_n = LD;
                end
            end
            LD: begin
                ramREN    = 1'b1;
                ramaddr   = daddr[own];
                word_done = (ramstate == ACCESS);
            end
            SWB: begin
                // Modified line is forwarded to the requester while RAM is updated
                ramWEN      = 1'b1;
                ramaddr     = daddr[sup];
                ramstore    = dstore[sup];
                dload[own]  = dstore[sup];
                ccwait[sup] = 1'b1;
                word_done   = (ramstate == ACCESS);
                if (word_done) dwait[sup] = 1'b0;
            end
            WB: begin
                ramWEN    = 1'b1;
                ramaddr   = daddr[own];
                ramstore  = dstore[own];
                word_done = (ramstate == ACCESS);
            end
            default: state_n = IDLE;
        endcase

        if (word_done) begin
            dwait[own] = 1'b0;
            if (cnt == LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                dptr_n  = wrap_inc(own);
            end else begin
                cnt_n = cnt + CNTW'(1);
            end
        end

        // Quiet bus while reset is held
        if (!nRST) begin
            iwait  = '1;
            dwait  = '1;
            ccwait = '0;
            ccinv  = '0;
            ramREN = 1'b0;
            ramWEN = 1'b0;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            own   <= '0;
            sup   <= '0;
            cnt   <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= state_n;
            own   <= own_n;
            sup   <= sup_n;
            cnt   <= cnt_n;
            dptr  <= dptr_n;
            iptr  <= iptr_n;
        end
    end

endmodule
